// File: rtl/exec_mul_ctrl.sv
// ============================================================================
// Module      : exec_mul_ctrl
// Description : Iterative radix-2 signed multiply sequencer for the execute
//               stage. It stalls the pipeline while it runs and pulses done
//               with the low WIDTH product bits and a signed-overflow flag.
//               Optional build macro MUL_EARLY_EXIT_EN ends the loop once the
//               remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_mul_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_done;
    logic [WIDTH-1:0]     r_out;
    logic                 r_ovf;

    logic                 w_launch;
    logic [WIDTH-1:0]     w_abs1;
    logic [WIDTH-1:0]     w_abs2;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_mplier_next;
    logic                 w_last;

    // Magnitudes are unsigned, so the most-negative operand keeps its value.
    assign w_abs1        = src1[WIDTH-1] ? -src1 : src1;
    assign w_abs2        = src2[WIDTH-1] ? -src2 : src2;
    assign w_launch      = start & ((r_state == S_IDLE) | (r_state == S_DONE)) & ~flush;
    assign w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod        = r_neg ? -w_acc_next : w_acc_next;
    assign w_mplier_next = r_mplier >> 1;

`ifdef MUL_EARLY_EXIT_EN
    assign w_last = (w_mplier_next == '0) || (r_count == c_LAST);
`else
    assign w_last = (r_count == c_LAST);
`endif

    assign busy     = (r_state == S_RUN);
    assign stall    = w_launch | busy;
    assign done     = r_done;
    assign out      = r_out;
    assign overflow = r_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_out    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
            end else if (w_launch) begin
                r_mcand  <= {{WIDTH{1'b0}}, w_abs1};
                r_mplier <= w_abs2;
                r_neg    <= src1[WIDTH-1] ^ src2[WIDTH-1];
                r_acc    <= '0;
                r_count  <= '0;
                r_state  <= S_RUN;
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= w_mplier_next;
                        r_count  <= r_count + c_CNT_W'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_out   <= w_prod[WIDTH-1:0];
                            r_ovf   <= (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
